// File: rtl/wall_map.sv
// Playfield wall bitmap: display read port, arbitrated collision queries,
// destructible-cell hits and built-in map loading.
module wall_map #(
  parameter int WIDTH       = 64,
  parameter int GAME_HEIGHT = 44
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_request_x,
  input  logic [5:0] i_request_y,
  input  logic       i_buzy,
  output logic       o_is_wall,
  input  logic       i_query_valid,
  input  logic [5:0] i_query_x,
  input  logic [5:0] i_query_y,
  output logic       o_query_done,
  output logic       o_query_wall,
  input  logic       i_hit_valid,
  input  logic [5:0] i_hit_x,
  input  logic [5:0] i_hit_y,
  input  logic       i_load,
  input  logic [1:0] i_map_sel,
  output logic       o_ready
);

  localparam int              RW       = $clog2(GAME_HEIGHT);
  localparam logic [RW-1:0]   LAST_ROW = RW'(GAME_HEIGHT - 1);
  localparam logic [6:0]      W_LIM    = 7'(WIDTH);
  localparam logic [6:0]      H_LIM    = 7'(GAME_HEIGHT);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_ACK = 2'd2} state_t;

  state_t                             state, nxt;
  logic [RW-1:0]                      row_cnt;
  logic [GAME_HEIGHT-1:0][WIDTH-1:0]  bitmap;
  logic [WIDTH-1:0]                   init_row;
  logic                               disp_bit, qry_bit, accept, hit_en;

  // Border is common to every map; each higher map index adds features on top.
  function automatic logic map_bit(input int x, input int y, input logic [1:0] sel);
    logic b;
    b = (x == 0) || (x == WIDTH - 1) || (y == 0) || (y == GAME_HEIGHT - 1);
    if (sel >= 2'd1 && (x % 8) == 4 && (y % 8) == 4)                   b = 1'b1;
    if (sel >= 2'd2 && (y == 21 || y == 22) && x >= 16 && x <= 47)      b = 1'b1;
    if (sel == 2'd3 && (x == 31 || x == 32) && y >= 8 && y <= 35)       b = 1'b1;
    return b;
  endfunction

  function automatic logic in_range(input logic [5:0] x, input logic [5:0] y);
    return ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
  endfunction

  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    assign init_row[c] = map_bit(c, int'(row_cnt), i_map_sel);
  end

  // Off-grid reads report wall so movers never leave the playfield.
  always_comb begin
    disp_bit = 1'b1;
    if (in_range(i_request_x, i_request_y)) disp_bit = bitmap[i_request_y][i_request_x];
  end

  always_comb begin
    qry_bit = 1'b1;
    if (in_range(i_query_x, i_query_y)) qry_bit = bitmap[i_query_y][i_query_x];
  end

  assign accept = (state == S_RUN) && !i_buzy && i_query_valid;
  assign hit_en = i_hit_valid && !i_load && (state != S_INIT) && in_range(i_hit_x, i_hit_y) &&
                  (i_hit_x != 6'd0) && ({1'b0, i_hit_x} != W_LIM - 7'd1) &&
                  (i_hit_y != 6'd0) && ({1'b0, i_hit_y} != H_LIM - 7'd1);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= nxt;
  end

  // FSM: next state; a load restarts INIT from any state
  always_comb begin
    nxt = state;
    case (state)
      S_INIT:  if (row_cnt == LAST_ROW) nxt = S_RUN;
      S_RUN:   if (accept) nxt = S_ACK;
      S_ACK:   nxt = S_RUN;
      default: nxt = S_INIT;
    endcase
    if (i_load) nxt = S_INIT;
  end

  // FSM: outputs
  always_comb begin
    o_ready      = (state == S_RUN) || (state == S_ACK);
    o_query_done = (state == S_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 row_cnt <= '0;
    else if (i_load)            row_cnt <= '0;
    else if (state == S_INIT)   row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_is_wall    <= 1'b0;
      o_query_wall <= 1'b0;
    end else begin
      if (state == S_INIT) o_is_wall <= 1'b0;
      else if (i_buzy)     o_is_wall <= disp_bit;
      if (accept)          o_query_wall <= qry_bit;
    end
  end

  // Bitmap needs no reset: INIT rewrites every row before RUN.
  always_ff @(posedge clk) begin
    if (state == S_INIT) bitmap[row_cnt] <= init_row;
    else if (hit_en)     bitmap[i_hit_y][i_hit_x] <= 1'b0;
  end

endmodule
